// File: rtl/tl_ul_arb2_if.sv
// One TileLink-UL link (A and D channels) between a master and a slave.
// Handshake: a beat transfers on a rising clock edge where valid && ready are both
// high; the sender holds valid and every field stable until that edge, and ready may depend on valid.
interface tl_ul_arb2_if #(
  parameter int SRC_W = 1
);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [1:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;
  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_size;
  logic             d_denied;
  logic [SRC_W-1:0] d_source;
  logic [31:0]      d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_denied, d_source, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_denied, d_source, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_arb2.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin A channel with grant lock
// on stall, source tagging with the master index, and per-master outstanding caps.
module tl_ul_arb2 #(
  parameter  int SRC_W   = 1,
  parameter  int MAX_OUT = 2,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  tl_ul_arb2_if.slave      m0,
  tl_ul_arb2_if.slave      m1,
  tl_ul_arb2_if.master     s,
  output logic             busy,
  output logic             err_unexp_d,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             err_q;

  logic elig0, elig1, has_win, win, a_valid_raw;
  logic a_fire, fire0, fire1;
  logic d_sel, d_fire, dret0, dret1;

  assign elig0 = m0.a_valid && (cnt0_q < CNT_W'(MAX_OUT));
  assign elig1 = m1.a_valid && (cnt1_q < CNT_W'(MAX_OUT));

  // A locked grant skips the cap check so a stalled request keeps its fields on the slave port.
  always_comb begin
    state_d     = state_q;
    has_win     = 1'b0;
    win         = 1'b0;
    a_valid_raw = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (elig0 && elig1) begin
          has_win = 1'b1;
          win     = rr_q;
        end else if (elig0) begin
          has_win = 1'b1;
        end else if (elig1) begin
          has_win = 1'b1;
          win     = 1'b1;
        end
        a_valid_raw = has_win;
        if (has_win && !s.a_ready) state_d = win ? LOCK1 : LOCK0;
      end
      LOCK0: begin
        has_win     = 1'b1;
        a_valid_raw = m0.a_valid;
        if (m0.a_valid && s.a_ready) state_d = UNLOCKED;
      end
      LOCK1: begin
        has_win     = 1'b1;
        win         = 1'b1;
        a_valid_raw = m1.a_valid;
        if (m1.a_valid && s.a_ready) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign s.a_valid   = reset_n && a_valid_raw;
  assign m0.a_ready  = reset_n && has_win && !win && s.a_ready;
  assign m1.a_ready  = reset_n && has_win && win && s.a_ready;
  assign s.a_opcode  = win ? m1.a_opcode  : m0.a_opcode;
  assign s.a_param   = win ? m1.a_param   : m0.a_param;
  assign s.a_size    = win ? m1.a_size    : m0.a_size;
  assign s.a_address = win ? m1.a_address : m0.a_address;
  assign s.a_mask    = win ? m1.a_mask    : m0.a_mask;
  assign s.a_data    = win ? m1.a_data    : m0.a_data;
  assign s.a_source  = {win, (win ? m1.a_source : m0.a_source)};

  assign a_fire = s.a_valid && s.a_ready;
  assign fire0  = a_fire && !win;
  assign fire1  = a_fire && win;

  // The top source bit is the tag added on the A side; it picks the returning master.
  assign d_sel       = s.d_source[SRC_W];
  assign m0.d_valid  = reset_n && s.d_valid && !d_sel;
  assign m1.d_valid  = reset_n && s.d_valid && d_sel;
  assign s.d_ready   = reset_n && (d_sel ? m1.d_ready : m0.d_ready);
  assign m0.d_opcode = s.d_opcode;
  assign m1.d_opcode = s.d_opcode;
  assign m0.d_size   = s.d_size;
  assign m1.d_size   = s.d_size;
  assign m0.d_denied = s.d_denied;
  assign m1.d_denied = s.d_denied;
  assign m0.d_data   = s.d_data;
  assign m1.d_data   = s.d_data;
  assign m0.d_source = s.d_source[SRC_W-1:0];
  assign m1.d_source = s.d_source[SRC_W-1:0];

  assign d_fire = s.d_valid && s.d_ready;
  assign dret0  = d_fire && !d_sel;
  assign dret1  = d_fire && d_sel;

  // A response with nothing outstanding leaves the count at zero rather than wrapping.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec) r = c + CNT_W'(1);
    else if (dec && !inc && (c != '0)) r = c - CNT_W'(1);
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNLOCKED;
      rr_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (a_fire) rr_q <= ~win;
      cnt0_q <= next_cnt(cnt0_q, fire0, dret0);
      cnt1_q <= next_cnt(cnt1_q, fire1, dret1);
      if ((dret0 && (cnt0_q == '0)) || (dret1 && (cnt1_q == '0))) err_q <= 1'b1;
    end
  end

  assign busy        = (|cnt0_q) || (|cnt1_q);
  assign err_unexp_d = err_q;
  assign state       = state_q;
  assign cnt_0       = cnt0_q;
  assign cnt_1       = cnt1_q;
endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-master to one-slave TileLink-UL arbiter for the E21 testbench fabric, e.g. core data port plus testbench DMA/debug injector sharing one slave port.
- Arbitrates the A channel round-robin and holds the grant while a request is stalled, so A-channel fields stay stable as the protocol monitor requires.
- Tags the source with the master index and routes D responses back by that tag.
- Tracks outstanding requests per master, enforces a cap, and flags unexpected responses.

Parameters:
- SRC_W, 1, width of each master's a/d source field; slave source is SRC_W+1.
- MAX_OUT, 2, maximum outstanding (A accepted, D not yet returned) requests per master; minimum 1.
- CNT_W, $clog2(MAX_OUT+1), outstanding counter width (derived).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mN_a_valid / mN_a_ready  in / out  1 / 1  A handshake, master N (N = 0,1; every mN_ line exists for m0 and m1).
- mN_a_opcode  in  3  A opcode.
- mN_a_param  in  3  A param.
- mN_a_size  in  2  log2 bytes.
- mN_a_source  in  SRC_W  master-local source.
- mN_a_address  in  32  byte address.
- mN_a_mask  in  4  byte mask.
- mN_a_data  in  32  put data.
- s_a_valid / s_a_ready  out / in  1 / 1  slave A handshake.
- s_a_opcode, s_a_param, s_a_size, s_a_address, s_a_mask, s_a_data  out  3, 3, 2, 32, 4, 32  muxed A fields.
- s_a_source  out  SRC_W+1  {master index, mN_a_source}.
- s_d_valid / s_d_ready  in / out  1 / 1  slave D handshake.
- s_d_opcode, s_d_size, s_d_denied, s_d_data  in  3, 2, 1, 32  D fields.
- s_d_source  in  SRC_W+1  MSB selects master.
- mN_d_valid / mN_d_ready  out / in  1 / 1  D handshake, master N.
- mN_d_opcode, mN_d_size, mN_d_denied, mN_d_data  out  3, 2, 1, 32  D fields, broadcast to both masters.
- mN_d_source  out  SRC_W  s_d_source with MSB stripped.
- busy  out  1  any outstanding count nonzero.
- err_unexp_d  out  1  sticky: D response returned to a master with zero outstanding.

Behaviour:
- Reset (async, reset_n low):
  - Counters 0, rr pointer = m0 priority, lock cleared, err_unexp_d 0.
  - While reset_n is low, force s_a_valid, mN_a_ready, s_d_ready and mN_d_valid to 0.
- Eligibility: elig_N = mN_a_valid && cnt_N < MAX_OUT.
- States: UNLOCKED, LOCK0, LOCK1.
- UNLOCKED:
  - Pick combinationally among eligible masters. Both eligible: the rr-priority master wins.
  - Drive s_a_* from the winner; s_a_valid = winner exists.
  - mN_a_ready = s_a_ready && winner == N; loser's ready is 0.
  - Winner with s_a_valid && !s_a_ready: next state LOCKn.
- LOCKn:
  - Mux fixed to master n; no re-arbitration and no cap re-check.
  - On fire, return to UNLOCKED.
  - Master n dropping valid while locked is a master protocol violation and is not handled; the lock persists.
- Fire of master k (s_a_valid && s_a_ready): cnt_k increments; rr priority moves to the other master.
- Zero-latency passthrough: no A or D pipeline registers.
- D routing:
  - sel = s_d_source[SRC_W]; mN_d_valid = s_d_valid && sel == N; s_d_ready = m(sel)_d_ready.
  - D fires when s_d_valid && s_d_ready; cnt_sel decrements.
- Same-cycle A fire and D fire for the same master: count unchanged.
- D fire with cnt_sel == 0: count stays 0 (no underflow), err_unexp_d sets; it clears only on reset.
- A cap-full master (cnt == MAX_OUT) is invisible to arbitration; the other master can win every cycle.
- busy = |cnt_0 || |cnt_1, registered-count based.

Test Plan:
- Both masters valid every cycle, s_a_ready=1, MAX_OUT=2, D returned the next cycle → grants alternate m0, m1, m0, m1; s_a_source MSB alternates 0, 1.
- m1 alone valid, s_a_ready low 3 cycles; m0 raises valid in cycle 2 → s_a_* stays on m1 (address unchanged), m0_a_ready=0; after m1 fires, m0 is granted next.
- m0 issues 2 requests, no D → cnt_0=2, m0 blocked with valid high, m1 still granted; one D with source MSB=0 → m0 eligible next cycle.
- D with s_d_source=2'b10 (SRC_W=1) → m1_d_valid=1, m1_d_source=0, s_d_ready follows m1_d_ready, m0_d_valid=0.
- D for m0 with cnt_0=0 → err_unexp_d=1 and stays 1; cnt_0 stays 0.
- Drop reset_n mid-lock with cnt_0=1 → all counts 0, busy=0, lock cleared, m0 priority after release.
